// File: rtl/hello_world_pkg.sv
// Shared constants and types for the fixed-message UART demo.
// The optional even-parity frame is selected with HELLO_WORLD_PARITY_EN.
package hello_world_pkg;

    localparam int MSG_LEN = 13;
    localparam logic [3:0] LAST_IDX = 4'd12;

    // "Hello World\r\n"
    localparam logic [7:0] MSG [0:MSG_LEN-1] = '{
        8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
        8'h6F, 8'h72, 8'h6C, 8'h64, 8'h0D, 8'h0A
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    function automatic logic [7:0] msg_byte(input logic [3:0] idx);
        return (idx <= LAST_IDX) ? MSG[idx] : 8'h00;
    endfunction

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// Single-byte UART serialiser: 8N1 by default, 8E1 when HELLO_WORLD_PARITY_EN
// is defined. done pulses during the final cycle of the stop bit.
module uart_tx
    import hello_world_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);

`ifdef HELLO_WORLD_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int SHIFT_W = FRAME_BITS - 1;
    localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_PRE = CNT_W'(CLOCKS_PER_BIT - 2);
    localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

    logic [CNT_W-1:0]   baud_cnt_r;
    logic [3:0]         bit_cnt_r;
    logic [SHIFT_W-1:0] shift_r;
    logic               tx_r;
    logic               busy_r;
    logic               done_r;
    logic [SHIFT_W-1:0] frame_s;

    // Everything after the start bit, shifted out LSB first
    always_comb begin
`ifdef HELLO_WORLD_PARITY_EN
        frame_s = {1'b1, even_parity(byte_in), byte_in};
`else
        frame_s = {1'b1, byte_in};
`endif
    end

    // Baud/bit counters and the registered serial line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r  <= 4'd0;
            shift_r    <= {SHIFT_W{1'b1}};
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (!busy_r) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r  <= 4'd0;
            done_r     <= 1'b0;
            if (start) begin
                busy_r  <= 1'b1;
                tx_r    <= 1'b0;
                shift_r <= frame_s;
            end else begin
                tx_r <= 1'b1;
            end
        end else begin
            // Flag completion one cycle early so the next frame can follow with a single idle cycle
            done_r <= (bit_cnt_r == BIT_LAST) && (baud_cnt_r == BAUD_PRE);
            if (baud_cnt_r == BAUD_LAST) begin
                baud_cnt_r <= {CNT_W{1'b0}};
                if (bit_cnt_r == BIT_LAST) begin
                    busy_r    <= 1'b0;
                    tx_r      <= 1'b1;
                    bit_cnt_r <= 4'd0;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                    tx_r      <= shift_r[0];
                    shift_r   <= {1'b1, shift_r[SHIFT_W-1:1]};
                end
            end else begin
                baud_cnt_r <= baud_cnt_r + CNT_W'(1);
            end
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: rtl/hello_world.sv
// Sends "Hello World\r\n" over a UART line on each trigger while idle.
// Define HELLO_WORLD_PARITY_EN for 8E1 framing instead of 8N1.
module hello_world
    import hello_world_pkg::*;
#(
    parameter int CLOCK_RATE     = 10,
    parameter int BAUD_RATE      = 1,
    parameter int CLOCKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    output logic       sending,
    output logic       tx,
    output logic [7:0] data
);

    if (CLOCKS_PER_BIT < 2) begin : g_cpb_check
        $error("hello_world: CLOCKS_PER_BIT must be at least 2");
    end

    state_t     state_r;
    state_t     state_s;
    logic [3:0] idx_r;
    logic [3:0] idx_s;
    logic       sending_r;
    logic       sending_s;
    logic [7:0] data_r;
    logic [7:0] data_s;
    logic       start_s;
    logic       tx_s;
    logic       busy_s;
    logic       done_s;

    uart_tx #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_uart_tx (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s),
        .byte_in(data_r),
        .tx     (tx_s),
        .busy   (busy_s),
        .done   (done_s)
    );

    // Message sequencer: next state, byte index and debug outputs
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        sending_s = sending_r;
        data_s    = data_r;
        start_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trigger) begin
                    state_s   = ST_LOAD;
                    sending_s = 1'b1;
                    data_s    = msg_byte(idx_r);
                end else begin
                    sending_s = 1'b0;
                    data_s    = 8'h00;
                end
            end
            ST_LOAD: begin
                if (!busy_s) begin
                    start_s = 1'b1;
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_SEND: begin
                if (done_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_s   = ST_IDLE;
                        idx_s     = 4'd0;
                        sending_s = 1'b0;
                        data_s    = 8'h00;
                    end else begin
                        state_s = ST_LOAD;
                        idx_s   = idx_r + 4'd1;
                        data_s  = msg_byte(idx_r + 4'd1);
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                idx_s     = 4'd0;
                sending_s = 1'b0;
                data_s    = 8'h00;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= 4'd0;
            sending_r <= 1'b0;
            data_r    <= 8'h00;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            sending_r <= sending_s;
            data_r    <= data_s;
        end
    end

    assign sending = sending_r;
    assign tx      = tx_s;
    assign data    = data_r;

endmodule

// File: tb/tb_hello_world.sv
// Randomised self-checking bench for hello_world against a frame-level line model.
// Build with HELLO_WORLD_PARITY_EN defined to check the 8E1 variant.
module tb_hello_world;

    localparam int CPB = 10;
`ifdef HELLO_WORLD_PARITY_EN
    localparam int FRAME_BITS = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int FRAME_BITS = 10;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NBYTES = 13;

    logic       clk;
    logic       rst;
    logic       trigger;
    logic       sending;
    logic       tx;
    logic [7:0] data;

    string msg_str = "Hello World\r\n";
    int    check_cnt = 0;
    int    error_cnt = 0;
    int    cyc_cnt = 0;

    hello_world #(
        .CLOCK_RATE(10),
        .BAUD_RATE (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .trigger(trigger),
        .sending(sending),
        .tx     (tx),
        .data   (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level for bit slot i of a frame carrying b
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        else if (i <= 8) return b[i-1];
        else if (PAR_EN && i == 9) return ($countones(b) % 2) == 1;
        else return 1'b1;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc_cnt++;
    endtask

    task automatic idle_check(input int n);
        for (int j = 0; j < n; j++) begin
            check_eq("idle_tx", tx, 1);
            check_eq("idle_sending", sending, 0);
            check_eq("idle_data", data, 8'h00);
            tick();
        end
    endtask

    task automatic start_message();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check_eq("sending_rise", sending, 1);
        check_eq("first_data", data, 8'h48);
        check_eq("load_tx_idle", tx, 1);
    endtask

    // Caller is at the negedge of the first LOAD cycle
    task automatic recv_message(input int retrig_byte, input int abort_byte,
                                input bit hold_end, output bit aborted);
        logic [7:0] b;
        logic [7:0] dec;
        int         wait_cnt;
        int         abort_cyc;
        aborted   = 1'b0;
        cyc_cnt   = 0;
        abort_cyc = $urandom_range(0, FRAME_BITS * CPB - 1);
        for (int k = 0; k < NBYTES; k++) begin
            b = msg_str[k];
            wait_cnt = 0;
            while (tx !== 1'b0 && wait_cnt < 2 * CPB) begin
                check_eq("load_data", data, b);
                tick();
                wait_cnt++;
            end
            check_eq("start_gap_ok", (wait_cnt <= 1) ? 1 : 0, 1);
            if (wait_cnt > 1) begin
                aborted = 1'b1;
                return;
            end
            dec = 8'h00;
            for (int i = 0; i < FRAME_BITS; i++) begin
                for (int c = 0; c < CPB; c++) begin
                    if (k == abort_byte && i * CPB + c == abort_cyc) begin
                        #2 rst = 1'b1;
                        #1;
                        check_eq("async_rst_tx", tx, 1);
                        check_eq("async_rst_sending", sending, 0);
                        check_eq("async_rst_data", data, 8'h00);
                        trigger = 1'b0;
                        tick();
                        rst = 1'b0;
                        aborted = 1'b1;
                        return;
                    end
                    trigger = ((k == retrig_byte && i >= 1 && i < 4) ||
                               (hold_end && k == NBYTES - 1 && i == FRAME_BITS - 1)) ? 1'b1 : 1'b0;
                    check_eq("frame_tx", tx, exp_bit(b, i));
                    check_eq("frame_data", data, b);
                    check_eq("frame_sending", sending, 1);
                    if (c == CPB / 2 && i >= 1 && i <= 8) dec[i-1] = tx;
                    tick();
                end
            end
            check_eq("decoded_byte", dec, b);
        end
        check_eq("end_sending", sending, 0);
        check_eq("end_tx", tx, 1);
        check_eq("end_data", data, 8'h00);
        check_eq("msg_cycles_ok",
                 (cyc_cnt >= NBYTES * FRAME_BITS * CPB && cyc_cnt <= NBYTES * (FRAME_BITS * CPB + 1)) ? 1 : 0, 1);
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        trigger = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit ab;
        rst = 1'b1;
        trigger = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_tx", tx, 1);
        check_eq("reset_sending", sending, 0);
        check_eq("reset_data", data, 8'h00);
        rst = 1'b0;
        idle_check(50);

        // Plain message right after reset
        start_message();
        recv_message(-1, -1, 1'b0, ab);
        check_eq("no_abort_plain", ab, 0);
        if (ab) hard_reset();
        idle_check(20);

        // Retrigger during byte 5 must be ignored
        idle_check($urandom_range(1, 8));
        start_message();
        recv_message(5, -1, 1'b0, ab);
        check_eq("no_abort_retrig", ab, 0);
        if (ab) hard_reset();
        idle_check(20);

        // Reset during byte 3, then a fresh message from 'H'
        start_message();
        recv_message(-1, 3, 1'b0, ab);
        check_eq("abort_taken", ab, 1);
        idle_check($urandom_range(5, 12));
        start_message();
        recv_message(-1, -1, 1'b0, ab);
        check_eq("no_abort_restart", ab, 0);
        if (ab) hard_reset();
        idle_check(10);

        // Trigger held high across the end restarts on the next cycle
        start_message();
        recv_message(-1, -1, 1'b1, ab);
        check_eq("no_abort_hold", ab, 0);
        if (ab) hard_reset();
        tick();
        trigger = 1'b0;
        check_eq("level_restart_sending", sending, 1);
        check_eq("level_restart_data", data, 8'h48);
        recv_message(-1, -1, 1'b0, ab);
        check_eq("no_abort_chain", ab, 0);
        if (ab) hard_reset();
        idle_check(10);

        $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
        $finish;
    end

endmodule
